imem_boot_ctrl: RTL

- Owns the processor's writable 256x32 instruction store and sequences its life cycle: host program load, zero-fill of unused words, then release of the CPU to fetch.
- Sits between a host loader (valid/ready word stream) and the single-cycle LEGv8 core's fetch port.
- Holds the core in reset until a complete, zero-padded image is present.

---
 rtl/imem_pkg.sv | 10 +
 rtl/imem_ram.sv | 28 ++
 rtl/imem_boot_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared state encoding and constants for the instruction-store boot controller
package imem_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, FILL, RUN} imem_state_t;

  localparam int          IMEM_DEPTH     = 256;
  localparam int          IMEM_AW        = 8;
  localparam logic [31:0] IMEM_ZERO_WORD = 32'h0;

endpackage

// File: rtl/imem_ram.sv
// rtl/imem_ram.sv - instruction storage, one synchronous write port and one asynchronous read port
module imem_ram
  import imem_pkg::*;
#(
  parameter int N     = 32,
  parameter int AW    = IMEM_AW,
  parameter int DEPTH = IMEM_DEPTH
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [N-1:0]  q
);

  logic [N-1:0] mem [DEPTH];

  // Contents are deliberately not reset; FILL guarantees no stale word survives into RUN.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign q = mem[raddr];

endmodule

// File: rtl/imem_boot_ctrl.sv
// rtl/imem_boot_ctrl.sv - host load, zero-fill and CPU release sequencing for the instruction store
// Optional running checksum of host words: IMEM_CHECKSUM_EN
module imem_boot_ctrl
  import imem_pkg::*;
#(
  parameter int N  = 32,
  parameter int AW = IMEM_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [N-1:0]  ld_data,
  input  logic          ld_last,
  input  logic          reload,
  input  logic [AW-1:0] fetch_addr,
  output logic [N-1:0]  instr,
  output logic          cpu_reset,
  output logic          busy,
`ifdef IMEM_CHECKSUM_EN
  output logic [N-1:0]  checksum,
`endif
  output logic [AW:0]   loaded_count
);

  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};
  localparam logic [AW:0]   COUNT_MAX = (AW+1)'(2**AW);

  imem_state_t   state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW:0]   loaded_count_q, loaded_count_d;
  logic          cpu_reset_q, cpu_reset_d;
  logic          busy_q, busy_d;
  logic          accept;
  logic          we;
  logic [N-1:0]  wdata;
  logic [N-1:0]  rdata;

  assign ld_ready = ((state_q == IDLE) || (state_q == LOAD)) && !reload;
  assign accept   = ld_valid && ld_ready;

  always_comb begin
    state_d        = state_q;
    wptr_d         = wptr_q;
    loaded_count_d = loaded_count_q;
    cpu_reset_d    = (state_q != RUN);
    we             = 1'b0;
    wdata          = ld_data;
    if (reload) begin
      // Abort wins over any handshake; IDLE re-entry clears the pointer and count.
      if (state_q != IDLE) begin
        state_d        = IDLE;
        wptr_d         = '0;
        loaded_count_d = '0;
        cpu_reset_d    = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE, LOAD: begin
          if (accept) begin
            we     = 1'b1;
            wptr_d = wptr_q + 1'b1;
            if (loaded_count_q != COUNT_MAX) begin
              loaded_count_d = loaded_count_q + 1'b1;
            end
            // The top address is an implicit last word: the image is full, no wrap.
            if (wptr_q == LAST_ADDR) begin
              state_d = RUN;
            end else if (ld_last) begin
              state_d = FILL;
            end else begin
              state_d = LOAD;
            end
          end
        end
        FILL: begin
          we     = 1'b1;
          wdata  = N'(IMEM_ZERO_WORD);
          wptr_d = wptr_q + 1'b1;
          if (wptr_q == LAST_ADDR) begin
            state_d = RUN;
          end
        end
        default: begin
        end
      endcase
    end
    busy_d = (state_d == LOAD) || (state_d == FILL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      wptr_q         <= '0;
      loaded_count_q <= '0;
      cpu_reset_q    <= 1'b1;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      wptr_q         <= wptr_d;
      loaded_count_q <= loaded_count_d;
      cpu_reset_q    <= cpu_reset_d;
      busy_q         <= busy_d;
    end
  end

`ifdef IMEM_CHECKSUM_EN
  logic [N-1:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (reload && (state_q != IDLE)) begin
      checksum_d = '0;
    end else if (accept) begin
      checksum_d = checksum_q + ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`endif

  imem_ram #(
    .N     (N),
    .AW    (AW),
    .DEPTH (2**AW)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wptr_q),
    .wdata (wdata),
    .raddr (fetch_addr),
    .q     (rdata)
  );

  // Core sees only zeros until the image is complete.
  assign instr        = (state_q == RUN) ? rdata : '0;
  assign cpu_reset    = cpu_reset_q;
  assign busy         = busy_q;
  assign loaded_count = loaded_count_q;

endmodule
